// File: rtl/board_io_ctrl.sv
// Board glue between PLL and core: button sync/debounce, core reset sequencing,
// and LED debug view of a selectable channel and bit window.
module board_io_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int NUM_LED         = 4,
  parameter int NUM_CH          = 4,
  parameter int CH_W            = 32,
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int RST_HOLD_CYCLES = 1024,
  parameter int SHOW_CYCLES     = 40000000
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       pll_locked,
  input  logic [NUM_BTN-1:0]                         btn_raw,
  input  logic [NUM_CH*CH_W-1:0]                     dbg,
  output logic [NUM_BTN-1:0]                         btn_db,
  output logic [NUM_BTN-1:0]                         btn_press,
  output logic                                       core_reset_n,
  output logic [(NUM_CH > 2 ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
  output logic [NUM_LED-1:0]                         led,
  output logic [1:0]                                 rst_state
);

  localparam int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (RST_HOLD_CYCLES > 2) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int SHOW_W = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
  localparam int NWIN   = CH_W / NUM_LED;
  localparam int WIN_W  = (NWIN > 2) ? $clog2(NWIN) : 1;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } rst_state_t;

  logic [NUM_BTN-1:0] btn_m, btn_s, db_next;
  logic               lock_m, lock_s, abort;
  logic [DB_W-1:0]    db_cnt   [NUM_BTN];
  logic [DB_W-1:0]    cnt_next [NUM_BTN];
  rst_state_t         state, state_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic [SEL_W-1:0]   sel_next;
  logic [WIN_W-1:0]   window, win_next;
  logic [SHOW_W-1:0]  show_cnt, show_next;
  logic               inc, dec;
  logic [CH_W-1:0]    ch_word;
  logic [NUM_LED-1:0] led_data;

  assign rst_state = state;

  // Debounce: a bit flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    db_next = btn_db;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_next[i] = '0;
      if (btn_s[i] != btn_db[i]) begin
        if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) db_next[i] = ~btn_db[i];
        else cnt_next[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  assign abort = ~lock_s | btn_db[0];

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    if (abort) begin
      state_next = ST_WAIT;
      hold_next  = '0;
    end else begin
      case (state)
        ST_WAIT: begin
          state_next = ST_HOLD;
          hold_next  = '0;
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
            state_next = ST_RUN;
            hold_next  = '0;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
        ST_RUN:  state_next = ST_RUN;
        default: state_next = ST_WAIT;
      endcase
    end
  end

  // Opposing presses in one cycle cancel out entirely.
  assign inc = btn_press[1] & ~btn_press[2];
  assign dec = btn_press[2] & ~btn_press[1];

  always_comb begin
    sel_next  = ch_sel;
    win_next  = window;
    show_next = (show_cnt != '0) ? show_cnt - 1'b1 : '0;
    if (inc) sel_next = (ch_sel == SEL_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
    else if (dec) sel_next = (ch_sel == '0) ? SEL_W'(NUM_CH - 1) : ch_sel - 1'b1;
    if (inc | dec) begin
      show_next = SHOW_W'(SHOW_CYCLES - 1);
      win_next  = '0;
    end else if (btn_press[3]) begin
      win_next = (window == WIN_W'(NWIN - 1)) ? '0 : window + 1'b1;
    end
  end

  assign ch_word  = dbg[ch_sel*CH_W +: CH_W];
  assign led_data = ch_word[window*NUM_LED +: NUM_LED];

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m        <= '0;
      btn_s        <= '0;
      lock_m       <= 1'b0;
      lock_s       <= 1'b0;
      btn_db       <= '0;
      btn_press    <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
      state        <= ST_WAIT;
      hold_cnt     <= '0;
      core_reset_n <= 1'b0;
      ch_sel       <= '0;
      window       <= '0;
      show_cnt     <= '0;
      led          <= '0;
    end else begin
      btn_m        <= btn_raw;
      btn_s        <= btn_m;
      lock_m       <= pll_locked;
      lock_s       <= lock_m;
      btn_db       <= db_next;
      btn_press    <= db_next & ~btn_db;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= cnt_next[i];
      state        <= state_next;
      hold_cnt     <= hold_next;
      core_reset_n <= (state_next == ST_RUN);
      ch_sel       <= sel_next;
      window       <= win_next;
      show_cnt     <= show_next;
      if (!core_reset_n)        led <= '1;
      else if (show_cnt != '0)  led <= NUM_LED'(ch_sel);
      else                      led <= led_data;
    end
  end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised board-level glue between the FPGA pins and the core, placed between the PLL and the `top` instance.
- Synchronises and debounces NUM_BTN push-buttons.
- Sequences the core reset from button 0 and the PLL lock, with a minimum hold time.
- Drives NUM_LED LEDs from a button-selected debug channel and bit window. A fixed register nibble is no longer hard-wired to the LEDs.

Parameters:
- NUM_BTN, 4: button count; must be ≥4 (buttons 0-3 have fixed roles).
- NUM_LED, 4: LED count.
- NUM_CH, 4: number of debug channels; must be ≥2.
- CH_W, 32: width of each debug channel; must be a multiple of NUM_LED.
- DEBOUNCE_CYCLES, 800000: stable cycles required before a button change is accepted (10 ms at 80 MHz).
- RST_HOLD_CYCLES, 1024: cycles core reset stays asserted after lock is good and button 0 is released.
- SHOW_CYCLES, 40000000: cycles the LEDs show the channel index after a selection change.

Ports:
- clk, in, 1: core clock (PLL output).
- reset, in, 1: synchronous, active-high block reset.
- pll_locked, in, 1: PLL lock, asynchronous to clk.
- btn_raw, in, NUM_BTN: raw buttons, asynchronous, active-high.
- dbg, in, NUM_CH*CH_W: debug channels; channel i is dbg[i*CH_W +: CH_W].
- btn_db, out, NUM_BTN: debounced button levels.
- btn_press, out, NUM_BTN: one-cycle pulse on each debounced 0→1 edge.
- core_reset_n, out, 1: active-low reset to the core.
- ch_sel, out, max(1,$clog2(NUM_CH)): currently selected channel.
- led, out, NUM_LED: LED drive (registered).

Behaviour:
- Reset values: btn_db=0, btn_press=0, core_reset_n=0, ch_sel=0, window=0, show counter=0, led=0. Both synchroniser stages clear to 0. Reset FSM enters WAIT.
- Synchronisers: 2-flop synchroniser on every btn_raw bit and on pll_locked. All downstream logic uses the synchronised values (btn_s, lock_s).
- Debounce, per bit, with a counter of width $clog2(DEBOUNCE_CYCLES):
  - if btn_s==btn_db, the counter is cleared;
  - otherwise the counter increments;
  - when the counter==DEBOUNCE_CYCLES-1 while still mismatched, btn_db flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
  - btn_press[i] = (next btn_db[i] & ~btn_db[i]), registered, so it is high for exactly the cycle in which btn_db rises.
- Reset FSM (core_reset_n=1 only in RUN):
  - abort condition = ~lock_s | btn_db[0]; it is evaluated in every state and sends the FSM to WAIT with the hold counter cleared. It has priority over all other transitions.
  - WAIT: if abort is low, go to HOLD with the hold counter at 0.
  - HOLD: the hold counter increments; at RST_HOLD_CYCLES-1, go to RUN.
  - RUN: stay until abort.
  - Lock loss mid-RUN deasserts core_reset_n on the next edge after lock_s falls.
- Channel and window select (active in all FSM states):
  - btn_press[1]: ch_sel ← (ch_sel+1) mod NUM_CH.
  - btn_press[2]: ch_sel ← (ch_sel==0 ? NUM_CH-1 : ch_sel-1).
  - Press[1] and press[2] in the same cycle: no change, and the show counter is not loaded.
  - Any ch_sel change loads the show counter with SHOW_CYCLES-1 and resets window to 0.
  - btn_press[3]: window ← (window+1) mod (CH_W/NUM_LED); does not affect the show counter.
  - The show counter decrements to 0 and saturates.
- LED output (registered, 1-cycle latency from dbg), priority order:
  1. core_reset_n==0: led = all ones.
  2. Show counter ≠ 0: led = ch_sel, zero-extended or truncated to NUM_LED.
  3. Otherwise: led = dbg[ch_sel*CH_W + window*NUM_LED +: NUM_LED].
- Asserting reset mid-operation discards all counters and state on the same edge; no partial debounce or hold progress survives.

Test Plan:
Common parameters: DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, SHOW_CYCLES=16, NUM_CH=4, CH_W=8, NUM_LED=4.
1. Power-up sequencing: reset for 3 cycles; pll_locked=1, btn_raw=0 → core_reset_n stays 0 and led=4'hF until 2 sync + 1 WAIT→HOLD + 8 HOLD cycles have elapsed, then core_reset_n=1. core_reset_n must not rise before that.
2. Button 0 pulse: 3-cycle pulse on btn_raw[0] while in RUN → btn_db[0] stays 0 and core_reset_n stays 1. Hold btn_raw[0] for 10 cycles → btn_db[0] rises 4 cycles after btn_s changes, and core_reset_n=0 on the next edge. After release, the full 8-cycle hold repeats.
3. Lock loss: pll_locked falls in RUN → core_reset_n=0 exactly 3 edges later. Lock returns → 8-cycle hold, then RUN.
4. Channel cycling:
   - dbg ch0=8'hA5, ch1=8'h3C, ch3=8'h96.
   - After settling in RUN, led=4'h5.
   - Press btn1 → led=4'h1 for 16 cycles, then 4'hC.
   - Press btn3 → led=4'h3.
   - Press btn2 twice → ch_sel=3, window=0, led=4'h6 after the show interval.
5. Simultaneous presses: btn_press[1] and btn_press[2] in the same cycle → ch_sel unchanged and show counter not loaded.
6. Mid-operation reset: assert reset with ch_sel=2, window=1, and a debounce count in progress → next cycle all outputs are at their reset values and the FSM is in WAIT.
